// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator: pixel type, 720p defaults,
// FSM state codes and the colour-bar palette.
package video_timing_pkg;

  typedef logic [23:0] rgb_t;

  localparam int unsigned HActive720p = 1280;
  localparam int unsigned HFp720p     = 110;
  localparam int unsigned HSync720p   = 40;
  localparam int unsigned HBp720p     = 220;
  localparam int unsigned VActive720p = 720;
  localparam int unsigned VFp720p     = 5;
  localparam int unsigned VSync720p   = 5;
  localparam int unsigned VBp720p     = 20;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam rgb_t BarWhite   = 24'hFFFFFF;
  localparam rgb_t BarYellow  = 24'hFFFF00;
  localparam rgb_t BarCyan    = 24'h00FFFF;
  localparam rgb_t BarGreen   = 24'h00FF00;
  localparam rgb_t BarMagenta = 24'hFF00FF;
  localparam rgb_t BarRed     = 24'hFF0000;
  localparam rgb_t BarBlue    = 24'h0000FF;
  localparam rgb_t BarBlack   = 24'h000000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    unique case (idx)
      3'd0: c = BarWhite;
      3'd1: c = BarYellow;
      3'd2: c = BarCyan;
      3'd3: c = BarGreen;
      3'd4: c = BarMagenta;
      3'd5: c = BarRed;
      3'd6: c = BarBlue;
      3'd7: c = BarBlack;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with the IDLE/RUN control FSM and region decode.
// sys_rst_n is an active-high asynchronous reset despite its name.
module video_timing_cnt
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive720p,
  parameter int unsigned H_FP     = HFp720p,
  parameter int unsigned H_SYNC   = HSync720p,
  parameter int unsigned H_BP     = HBp720p,
  parameter int unsigned V_ACTIVE = VActive720p,
  parameter int unsigned V_FP     = VFp720p,
  parameter int unsigned V_SYNC   = VSync720p,
  parameter int unsigned V_BP     = VBp720p
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  output logic        running,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        active,
  output logic        hs_region,
  output logic        vs_region,
  output logic        origin
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : gen_size_err
    $error("video_timing_cnt: H_TOTAL/V_TOTAL exceed 12-bit counter range");
  end

  localparam logic [11:0] HLast = 12'(H_TOTAL - 1);
  localparam logic [11:0] VLast = 12'(V_TOTAL - 1);

  logic [0:0]  state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic        h_wrap, v_wrap;
  logic [31:0] h_wide, v_wide;

  assign h_wrap = (h_q == HLast);
  assign v_wrap = (v_q == VLast);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (state_q == StIdle) begin
      h_d = '0;
      v_d = '0;
      if (en) state_d = StRun;
    end else begin
      h_d = h_wrap ? 12'd0 : h_q + 12'd1;
      if (h_wrap) v_d = v_wrap ? 12'd0 : v_q + 12'd1;
      // en is only honoured at the last cycle of a frame so frames are never cut short.
      if (h_wrap && v_wrap && !en) state_d = StIdle;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign h_wide    = {20'd0, h_q};
  assign v_wide    = {20'd0, v_q};
  assign running   = (state_q == StRun);
  assign h_cnt     = h_q;
  assign v_cnt     = v_q;
  // Region flags are qualified with running so IDLE never looks like pixel (0,0).
  assign active    = running && (h_wide < H_ACTIVE) && (v_wide < V_ACTIVE);
  assign hs_region = running && (h_wide >= H_ACTIVE + H_FP)
                     && (h_wide < H_ACTIVE + H_FP + H_SYNC);
  assign vs_region = running && (v_wide >= V_ACTIVE + V_FP)
                     && (v_wide < V_ACTIVE + V_FP + V_SYNC);
  assign origin    = running && (h_q == 12'd0) && (v_q == 12'd0);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters plus two register stages feeding the TMDS encoders.
// Define COLOR_BAR_EN to replace rgb_in with an internal 8-bar test pattern.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive720p,
  parameter int unsigned H_FP     = HFp720p,
  parameter int unsigned H_SYNC   = HSync720p,
  parameter int unsigned H_BP     = HBp720p,
  parameter int unsigned V_ACTIVE = VActive720p,
  parameter int unsigned V_FP     = VFp720p,
  parameter int unsigned V_SYNC   = VSync720p,
  parameter int unsigned V_BP     = VBp720p,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  input  logic [23:0] rgb_in,
  output logic        frame_start,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb_out
);

  logic        running, active, hs_region, vs_region, origin;
  logic [11:0] h_cnt, v_cnt;
  logic        hs_s1, vs_s1;
  rgb_t        pix_rgb;

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .running   (running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hs_region (hs_region),
    .vs_region (vs_region),
    .origin    (origin)
  );

`ifdef COLOR_BAR_EN
  localparam int unsigned BarW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_idx;
  logic       unused_rgb_in;

  assign unused_rgb_in = ^rgb_in;

  // Bar chosen from the stage-1 column so it lands in the same slot as de; bar 7 takes the rest.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if ({20'd0, pix_x} < 32'((i + 1) * BarW)) bar_idx = 3'(i);
    end
  end

  assign pix_rgb = bar_color(bar_idx);
`else
  assign pix_rgb = rgb_in;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      rgb_out     <= '0;
    end else begin
      pix_req     <= active;
      frame_start <= origin;
      hs_s1       <= hs_region;
      vs_s1       <= vs_region;
      if (active) begin
        pix_x <= h_cnt;
        pix_y <= v_cnt;
      end else if (!running) begin
        pix_x <= '0;
        pix_y <= '0;
      end
      de      <= pix_req;
      hsync   <= hs_s1 ? HS_POL : ~HS_POL;
      vsync   <= vs_s1 ? VS_POL : ~VS_POL;
      rgb_out <= pix_req ? pix_rgb : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a small raster; honours COLOR_BAR_EN if defined.
module tb_video_timing_gen;
  import video_timing_pkg::*;

`ifdef COLOR_BAR_EN
  localparam int HA = 16;
`else
  localparam int HA = 8;
`endif
  localparam int HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FL = HT * VT;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        en = 1'b0;
  logic        pix_req, frame_start, de, hsync, vsync;
  logic [11:0] pix_x, pix_y;
  rgb_t        rgb_in, rgb_out;
  rgb_t        salt = '0;

  int n_vec = 0;
  int n_err = 0;
  int cur_t = 0;
  int n_req = 0;
  int fs_t[$];

  rgb_t bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 sys_clk = ~sys_clk;

  // Source answers from the registered request address within the pix_req cycle.
`ifdef COLOR_BAR_EN
  assign rgb_in = 24'h123456;
`else
  assign rgb_in = {pix_y, pix_x} ^ salt;
`endif

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .rgb_in      (rgb_in),
    .frame_start (frame_start),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_out     (rgb_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic int hp(input int p);
    return p % HT;
  endfunction

  function automatic int vp(input int p);
    return (p / HT) % VT;
  endfunction

  function automatic bit act(input int p);
    return (hp(p) < HA) && (vp(p) < VA);
  endfunction

  function automatic rgb_t pixel(input int x, input int y);
`ifdef COLOR_BAR_EN
    int b;
    b = x / (HA / 8);
    if (b > 7) b = 7;
    return bars[b];
`else
    return {12'(y), 12'(x)} ^ salt;
`endif
  endfunction

  // Raster position p counts clocks since the first h=v=0 cycle; stage 1 shows p=t-1,
  // stage 2 shows p=t-2, and positions outside [0, run_len) are idle.
  task automatic check_cycle(input int t, input int run_len);
    int   p1, p2, ex, ey;
    bit   r1, r2, e_req, e_fs, e_de, e_hs, e_vs;
    rgb_t e_rgb;
    p1 = t - 1;
    p2 = t - 2;
    r1 = (p1 >= 0) && (p1 < run_len);
    r2 = (p2 >= 0) && (p2 < run_len);
    e_req = r1 && act(p1);
    e_fs  = r1 && (p1 % FL == 0);
    ex = 0;
    ey = 0;
    if (r1) begin
      if (vp(p1) < VA && hp(p1) < HA) begin
        ex = hp(p1); ey = vp(p1);
      end else if (vp(p1) < VA) begin
        ex = HA - 1; ey = vp(p1);
      end else begin
        ex = HA - 1; ey = VA - 1;
      end
    end
    e_de  = r2 && act(p2);
    e_hs  = r2 && (hp(p2) >= HA + HF) && (hp(p2) < HA + HF + HS);
    e_vs  = r2 && (vp(p2) >= VA + VF) && (vp(p2) < VA + VF + VS);
    e_rgb = e_de ? pixel(hp(p2), vp(p2)) : 24'h0;
    chk("pix_req", 32'(pix_req), 32'(e_req));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("pix_x", 32'(pix_x), 32'(ex));
    chk("pix_y", 32'(pix_y), 32'(ey));
    chk("de", 32'(de), 32'(e_de));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
  endtask

  // Raise en, follow the raster cycle by cycle; drop en after cycle drop_t, and optionally
  // assert reset asynchronously in the middle of cycle rst_t.
  task automatic run_seq(input int drop_t, input int stop_t, input int rst_t);
    int run_len;
    run_len = (drop_t / FL + 1) * FL;
    n_req = 0;
    fs_t.delete();
    @(negedge sys_clk);
    en = 1'b1;
    @(posedge sys_clk);
    for (int t = 0; t < stop_t; t++) begin
      @(negedge sys_clk);
      cur_t = t;
      if (t == rst_t) begin
        sys_rst_n = 1'b1;
        en = 1'b0;
        #1;
        check_cycle(t, 0);
        return;
      end
      check_cycle(t, run_len);
      if (pix_req) n_req++;
      if (frame_start) fs_t.push_back(t);
      if (t == drop_t) en = 1'b0;
    end
  endtask

  initial begin
    int d;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_cycle(0, 0);
    sys_rst_n = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge sys_clk);
      cur_t = t;
      check_cycle(t, 0);
    end

    // One frame, en dropped on line 2.
    d = 2 * HT + $urandom_range(0, HT - 1);
    run_seq(d, FL + 30, -1);
    chk("req_count_1", 32'(n_req), 32'(HA * VA));
    chk("frame_cnt_1", 32'(fs_t.size()), 32'd1);

    // Two frames, en dropped at a random point of the second one.
`ifndef COLOR_BAR_EN
    salt = rgb_t'($urandom);
`endif
    d = FL + $urandom_range(0, FL - 2);
    run_seq(d, 2 * FL + 30, -1);
    chk("req_count_2", 32'(n_req), 32'(2 * HA * VA));
    chk("frame_cnt_2", 32'(fs_t.size()), 32'd2);
    if (fs_t.size() == 2) chk("frame_len", 32'(fs_t[1] - fs_t[0]), 32'(FL));

    // Asynchronous reset at h=5 of a random active line, then restart.
    run_seq(3 * FL, 3 * FL, $urandom_range(0, VA - 1) * HT + 5);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    d = $urandom_range(0, FL - 2);
    run_seq(d, FL + 10, -1);
    chk("restart_fs", (fs_t.size() > 0) ? 32'(fs_t[0]) : 32'hFFFFFFFF, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
